// File: rtl/idu_pipe.sv
// IF/ID boundary stage: 2-entry skid buffer between fetch and execute with RV32I field decode.
// Optional build macro IDU_EBREAK_HALT_EN: retiring an ebreak from the head halts the stage until reset.
module idu_pipe #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [31:0]     in_inst_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [31:0]     out_inst_o,
    output logic [4:0]      out_rd_o,
    output logic [4:0]      out_rs1_o,
    output logic [4:0]      out_rs2_o,
    output logic [2:0]      out_funct3_o,
    output logic [6:0]      out_funct7_o,
    output logic [2:0]      out_fmt_o,
    output logic [31:0]     out_imm_o,
    output logic            out_illegal_o,
    output logic            halt_o
);

    // state    | meaning
    // ST_EMPTY | no entries buffered, out_valid=0, in_ready=1
    // ST_ONE   | head valid, tail free, in_ready=1
    // ST_TWO   | head and tail valid, in_ready=0
    // ST_HALT  | ebreak retired, stage frozen until rst (halt build only)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_SYS = 3'd6;
    localparam logic [2:0] FMT_UNK = 3'd7;

    state_e            state_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic [XLEN-1:0]   head_pc_q;
    logic [31:0]       head_inst_q;
    logic [XLEN-1:0]   tail_pc_q;
    logic [31:0]       tail_inst_q;
    logic              push;
    logic              pop;

    assign push = in_valid_i & in_ready_q;
    assign pop  = out_valid_q & out_ready_i;

`ifdef IDU_EBREAK_HALT_EN
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    logic halt_q;
    assign halt_o = halt_q;
`else
    assign halt_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            head_pc_q   <= RESET_PC;
            head_inst_q <= '0;
            tail_pc_q   <= '0;
            tail_inst_q <= '0;
`ifdef IDU_EBREAK_HALT_EN
            halt_q      <= 1'b0;
`endif
        end else
`ifdef IDU_EBREAK_HALT_EN
        if (state_q == ST_HALT) begin
            state_q <= ST_HALT;
        end else if (pop && (head_inst_q == EBREAK)) begin
            // the retiring ebreak wins over a concurrent flush or push
            state_q     <= ST_HALT;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            halt_q      <= 1'b1;
        end else
`endif
        if (flush_i) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_pc_q   <= in_pc_i;
                        head_inst_q <= in_inst_i;
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_pc_q   <= in_pc_i;
                        head_inst_q <= in_inst_i;
                    end else if (push) begin
                        tail_pc_q   <= in_pc_i;
                        tail_inst_q <= in_inst_i;
                        state_q     <= ST_TWO;
                        in_ready_q  <= 1'b0;
                    end else if (pop) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        head_pc_q   <= tail_pc_q;
                        head_inst_q <= tail_inst_q;
                        state_q     <= ST_ONE;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    logic [2:0]  fmt;
    logic        illegal;
    logic [31:0] imm;

    always_comb begin
        fmt     = FMT_UNK;
        illegal = 1'b1;
        case (head_inst_q[6:0])
            7'b0110011:                         begin fmt = FMT_R;   illegal = 1'b0; end
            7'b0010011, 7'b0000011, 7'b1100111: begin fmt = FMT_I;   illegal = 1'b0; end
            7'b0100011:                         begin fmt = FMT_S;   illegal = 1'b0; end
            7'b1100011:                         begin fmt = FMT_B;   illegal = 1'b0; end
            7'b0110111, 7'b0010111:             begin fmt = FMT_U;   illegal = 1'b0; end
            7'b1101111:                         begin fmt = FMT_J;   illegal = 1'b0; end
            7'b1110011:                         begin fmt = FMT_SYS; illegal = 1'b0; end
            default:                            begin fmt = FMT_UNK; illegal = 1'b1; end
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I, FMT_SYS: imm = {{20{head_inst_q[31]}}, head_inst_q[31:20]};
            FMT_S: imm = {{20{head_inst_q[31]}}, head_inst_q[31:25], head_inst_q[11:7]};
            FMT_B: imm = {{19{head_inst_q[31]}}, head_inst_q[31], head_inst_q[7],
                          head_inst_q[30:25], head_inst_q[11:8], 1'b0};
            FMT_U: imm = {head_inst_q[31:12], 12'b0};
            FMT_J: imm = {{11{head_inst_q[31]}}, head_inst_q[31], head_inst_q[19:12],
                          head_inst_q[20], head_inst_q[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign out_pc_o      = out_valid_q ? head_pc_q : RESET_PC;
    assign out_inst_o    = head_inst_q;
    assign out_rd_o      = head_inst_q[11:7];
    assign out_rs1_o     = head_inst_q[19:15];
    assign out_rs2_o     = head_inst_q[24:20];
    assign out_funct3_o  = head_inst_q[14:12];
    assign out_funct7_o  = head_inst_q[31:25];
    assign out_fmt_o     = fmt;
    assign out_imm_o     = imm;
    assign out_illegal_o = illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: handshake, buffering order, flush, decode and ebreak halt.
// Expectations follow the build macro IDU_EBREAK_HALT_EN when it is defined.
module tb_idu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [2:0]  out_fmt;
    logic [31:0] out_imm;
    logic        out_illegal;
    logic        halt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    idu_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_pc_i       (in_pc),
        .in_inst_i     (in_inst),
        .flush_i       (flush),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_pc_o      (out_pc),
        .out_inst_o    (out_inst),
        .out_rd_o      (out_rd),
        .out_rs1_o     (out_rs1),
        .out_rs2_o     (out_rs2),
        .out_funct3_o  (out_funct3),
        .out_funct7_o  (out_funct7),
        .out_fmt_o     (out_fmt),
        .out_imm_o     (out_imm),
        .out_illegal_o (out_illegal),
        .halt_o        (halt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        // 1: reset
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        chk("rst_out_pc",    out_pc,         32'h8000_0000);
        chk("rst_out_inst",  out_inst,       32'h0);
        chk("rst_halt",      32'(halt),      32'h0);

        // 2: single push, then push+pop replacing head
        out_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 32'h0142_8313);
        tick();
        chk("addi_valid", 32'(out_valid), 32'h1);
        chk("addi_pc",    out_pc,         32'h8000_0000);
        chk("addi_fmt",   32'(out_fmt),   32'h1);
        chk("addi_rd",    32'(out_rd),    32'h6);
        chk("addi_rs1",   32'(out_rs1),   32'h5);
        chk("addi_imm",   out_imm,        32'h0000_0014);
        chk("addi_ill",   32'(out_illegal), 32'h0);
        drive(1'b1, 32'h8000_0004, 32'hFF93_8413);
        tick();
        chk("addi2_pc",   out_pc,         32'h8000_0004);
        chk("addi2_imm",  out_imm,        32'hFFFF_FFF9);
        chk("addi2_rd",   32'(out_rd),    32'h8);
        chk("addi2_rs1",  32'(out_rs1),   32'h7);
        chk("addi2_ready", 32'(in_ready), 32'h1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("drain_valid", 32'(out_valid), 32'h0);

        // 3: fill while stalled, third push refused, drain in order
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 32'h0010_0093);
        tick();
        chk("fill1_ready", 32'(in_ready), 32'h1);
        drive(1'b1, 32'h104, 32'h0020_0113);
        tick();
        chk("fill2_ready", 32'(in_ready), 32'h0);
        drive(1'b1, 32'h108, 32'h0030_0193);
        tick();
        chk("fill3_ready", 32'(in_ready), 32'h0);
        chk("stall_head",  out_inst,      32'h0010_0093);
        chk("stall_pc",    out_pc,        32'h100);
        chk("stall_rd",    32'(out_rd),   32'h1);
        out_ready = 1'b1;
        tick();
        chk("pop1_head",   out_inst,      32'h0020_0113);
        chk("pop1_ready",  32'(in_ready), 32'h1);
        chk("pop1_valid",  32'(out_valid), 32'h1);
        tick();
        chk("pop2_head",   out_inst,      32'h0030_0193);
        chk("pop2_pc",     out_pc,        32'h108);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("pop3_valid",  32'(out_valid), 32'h0);

        // 4: decode of J, U, S, B, illegal
        drive(1'b1, 32'h200, 32'hFFDF_F0EF);
        tick();
        chk("jal_fmt", 32'(out_fmt), 32'h5);
        chk("jal_rd",  32'(out_rd),  32'h1);
        chk("jal_imm", out_imm,      32'hFFFF_FFFC);
        drive(1'b1, 32'h204, 32'h1234_52B7);
        tick();
        chk("lui_fmt", 32'(out_fmt), 32'h4);
        chk("lui_rd",  32'(out_rd),  32'h5);
        chk("lui_imm", out_imm,      32'h1234_5000);
        drive(1'b1, 32'h208, 32'h0061_2423);
        tick();
        chk("sw_fmt",  32'(out_fmt), 32'h2);
        chk("sw_rs1",  32'(out_rs1), 32'h2);
        chk("sw_rs2",  32'(out_rs2), 32'h6);
        chk("sw_f3",   32'(out_funct3), 32'h2);
        chk("sw_imm",  out_imm,      32'h0000_0008);
        drive(1'b1, 32'h20C, 32'hFE00_0EE3);
        tick();
        chk("beq_fmt", 32'(out_fmt), 32'h3);
        chk("beq_f7",  32'(out_funct7), 32'h7F);
        chk("beq_imm", out_imm,      32'hFFFF_FFFC);
        drive(1'b1, 32'h210, 32'h0000_0000);
        tick();
        chk("zero_ill", 32'(out_illegal), 32'h1);
        chk("zero_fmt", 32'(out_fmt),     32'h7);
        chk("zero_imm", out_imm,          32'h0);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("dec_drain", 32'(out_valid), 32'h0);

        // 5: flush with buffer full and a push offered
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 32'h0050_0293);
        tick();
        drive(1'b1, 32'h304, 32'h0060_0313);
        tick();
        chk("pre_flush_ready", 32'(in_ready), 32'h0);
        flush = 1'b1;
        drive(1'b1, 32'h308, 32'h0070_0393);
        tick();
        flush = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'h0);
        chk("flush_ready", 32'(in_ready),  32'h1);
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        tick();
        chk("flush_empty1", 32'(out_valid), 32'h0);
        tick();
        chk("flush_empty2", 32'(out_valid), 32'h0);
        drive(1'b1, 32'h400, 32'h0080_0413);
        tick();
        chk("post_flush_head", out_inst, 32'h0080_0413);
        drive(1'b0, 32'h0, 32'h0);
        tick();

        // 6: ebreak at head with a younger entry behind it
        out_ready = 1'b0;
        drive(1'b1, 32'h500, 32'h0010_0073);
        tick();
        drive(1'b1, 32'h504, 32'h0142_8313);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("ebrk_fmt", 32'(out_fmt), 32'h6);
        chk("ebrk_imm", out_imm,      32'h1);
        out_ready = 1'b1;
        tick();
`ifdef IDU_EBREAK_HALT_EN
        chk("halt_set",   32'(halt),      32'h1);
        chk("halt_valid", 32'(out_valid), 32'h0);
        chk("halt_ready", 32'(in_ready),  32'h0);
        flush = 1'b1;
        drive(1'b1, 32'h600, 32'h0010_0093);
        tick();
        tick();
        flush = 1'b0;
        chk("halt_hold",       32'(halt),      32'h1);
        chk("halt_hold_valid", 32'(out_valid), 32'h0);
        chk("halt_hold_ready", 32'(in_ready),  32'h0);
        drive(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("halt_rst",       32'(halt),     32'h0);
        chk("halt_rst_ready", 32'(in_ready), 32'h1);
`else
        chk("nohalt_halt",  32'(halt),      32'h0);
        chk("nohalt_valid", 32'(out_valid), 32'h1);
        chk("nohalt_head",  out_inst,       32'h0142_8313);
        chk("nohalt_pc",    out_pc,         32'h504);
        tick();
        chk("nohalt_empty", 32'(out_valid), 32'h0);
        chk("nohalt_ready", 32'(in_ready),  32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
